// File: rtl/reservatorio_rolhas.sv
// Cork-reservoir controller.
// Keeps a two-digit BCD cork count. The count goes up on each cork from the chute
// and down on each cork consumed. The refill valve opens while the level is low,
// and a fault is raised if refilling stalls.
// Ports:
//   clock, reset (async active-low)       - clocking / reset
//   tick                                  - timebase strobe for the refill watchdog
//   enabled                               - production line running
//   consume, refill_pulse                 - one cork out / one cork in
//   alarm_ack                             - operator clears the refill fault
//   rolhas_dezenas, rolhas_unidades       - BCD count digits
//   RO                                    - corks available (count != 00)
//   VE, ALARME                            - refill valve open / refill fault
//   underflow                             - consume attempted at count 00
//   state                                 - 00 IDLE, 01 REFILL, 10 FAULT
module reservatorio_rolhas #(
   parameter int unsigned LOW_LEVEL     = 5,
   parameter int unsigned FULL_LEVEL    = 20,
   parameter int unsigned TIMEOUT_TICKS = 8
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       tick,
   input  logic       enabled,
   input  logic       consume,
   input  logic       refill_pulse,
   input  logic       alarm_ack,
   output logic [3:0] rolhas_dezenas,
   output logic [3:0] rolhas_unidades,
   output logic       RO,
   output logic       VE,
   output logic       ALARME,
   output logic       underflow,
   output logic [1:0] state
);

   localparam int unsigned DIG_W = 4;
   localparam int unsigned CNT_W = 7;
   localparam int unsigned TMR_W = 4;
   localparam int unsigned ST_W  = 2;

   localparam logic [ST_W-1:0] ST_IDLE   = 2'b00;
   localparam logic [ST_W-1:0] ST_REFILL = 2'b01;
   localparam logic [ST_W-1:0] ST_FAULT  = 2'b10;

   logic [DIG_W-1:0] dez_d, uni_d;
   logic             uf_d, ro_d;
   logic [ST_W-1:0]  st_d;
   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic             ve_d, alarme_d;
   logic [CNT_W-1:0] cnt_bin;

   // Binary view of the registered count for the level thresholds
   assign cnt_bin = CNT_W'(rolhas_dezenas) * CNT_W'(10) + CNT_W'(rolhas_unidades);

   // BCD up/down count; simultaneous in/out cancels, including at 00
   always_comb begin
      dez_d = rolhas_dezenas;
      uni_d = rolhas_unidades;
      uf_d  = 1'b0;
      if (refill_pulse && !consume) begin
         if (!(rolhas_dezenas == DIG_W'(9) && rolhas_unidades == DIG_W'(9))) begin
            if (rolhas_unidades == DIG_W'(9)) begin
               uni_d = '0;
               dez_d = DIG_W'(rolhas_dezenas + DIG_W'(1));
            end else begin
               uni_d = DIG_W'(rolhas_unidades + DIG_W'(1));
            end
         end
      end else if (consume && !refill_pulse) begin
         if (rolhas_dezenas == '0 && rolhas_unidades == '0) begin
            uf_d = 1'b1;
         end else if (rolhas_unidades == '0) begin
            uni_d = DIG_W'(9);
            dez_d = DIG_W'(rolhas_dezenas - DIG_W'(1));
         end else begin
            uni_d = DIG_W'(rolhas_unidades - DIG_W'(1));
         end
      end
      ro_d = (dez_d != '0) || (uni_d != '0);
   end

   // State register (also the state output)
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
         tmr_q <= '0;
      end else begin
         state <= st_d;
         tmr_q <= tmr_d;
      end
   end

   // Next-state and watchdog timer; the timer restarts on every state change
   always_comb begin
      st_d  = state;
      tmr_d = tmr_q;
      case (state)
         ST_IDLE: begin
            tmr_d = '0;
            if (enabled && cnt_bin <= CNT_W'(LOW_LEVEL)) st_d = ST_REFILL;
         end
         ST_REFILL: begin
            if (refill_pulse)  tmr_d = '0;
            else if (tick)     tmr_d = TMR_W'(tmr_q + TMR_W'(1));
            if (cnt_bin >= CNT_W'(FULL_LEVEL))
               st_d = ST_IDLE;
            else if (!enabled)
               st_d = ST_IDLE;
            else if (tick && !refill_pulse && tmr_q == TMR_W'(TIMEOUT_TICKS - 1))
               st_d = ST_FAULT;
         end
         ST_FAULT: begin
            tmr_d = '0;
            if (alarm_ack) st_d = ST_IDLE;
         end
         default: begin
            st_d  = ST_IDLE;
            tmr_d = '0;
         end
      endcase
      if (st_d != state) tmr_d = '0;
   end

   // Moore outputs decoded from the next state so they register alongside it
   always_comb begin
      ve_d     = (st_d == ST_REFILL);
      alarme_d = (st_d == ST_FAULT);
   end

   // Registered count and outputs
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rolhas_dezenas  <= '0;
         rolhas_unidades <= '0;
         RO              <= 1'b0;
         underflow       <= 1'b0;
         VE              <= 1'b0;
         ALARME          <= 1'b0;
      end else begin
         rolhas_dezenas  <= dez_d;
         rolhas_unidades <= uni_d;
         RO              <= ro_d;
         underflow       <= uf_d;
         VE              <= ve_d;
         ALARME          <= alarme_d;
      end
   end

endmodule

// File: tb/tb_reservatorio_rolhas.sv
// Self-checking bench for reservatorio_rolhas: vector table, directed corner
// sequences and random traffic, all compared against an integer reference model.
module tb_reservatorio_rolhas;

   localparam int LOW  = 5;
   localparam int FULL = 20;
   localparam int TO   = 8;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       tick = 1'b0, enabled = 1'b0, consume = 1'b0, refill_pulse = 1'b0, alarm_ack = 1'b0;
   logic [3:0] rolhas_dezenas, rolhas_unidades;
   logic       RO, VE, ALARME, underflow;
   logic [1:0] state;

   int total = 0;
   int bad   = 0;

   // reference model: count as plain integer, state 0/1/2, timer
   int m_cnt = 0, m_st = 0, m_tmr = 0, m_uf = 0;

   reservatorio_rolhas #(.LOW_LEVEL(LOW), .FULL_LEVEL(FULL), .TIMEOUT_TICKS(TO)) dut (
      .clock(clock), .reset(reset), .tick(tick), .enabled(enabled), .consume(consume),
      .refill_pulse(refill_pulse), .alarm_ack(alarm_ack),
      .rolhas_dezenas(rolhas_dezenas), .rolhas_unidades(rolhas_unidades),
      .RO(RO), .VE(VE), .ALARME(ALARME), .underflow(underflow), .state(state)
   );

   always #5 clock = ~clock;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s act=%0d exp=%0d t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic int dut_cnt();
      return int'(rolhas_dezenas) * 10 + int'(rolhas_unidades);
   endfunction

   task automatic model_reset();
      m_cnt = 0; m_st = 0; m_tmr = 0; m_uf = 0;
   endtask

   task automatic model_update(input bit en, input bit cons, input bit rf, input bit tk, input bit ack);
      int c = m_cnt;
      int s = m_st;
      int t = m_tmr;
      int ns;
      int nt;
      if (!reset) begin
         model_reset();
         return;
      end
      m_uf = 0;
      if (rf && !cons)      m_cnt = (c == 99) ? 99 : c + 1;
      else if (cons && !rf) begin
         if (c == 0) m_uf = 1;
         else        m_cnt = c - 1;
      end
      ns = s;
      nt = t;
      if (s == 0) begin
         nt = 0;
         if (en && c <= LOW) ns = 1;
      end else if (s == 1) begin
         nt = rf ? 0 : (tk ? t + 1 : t);
         if (c >= FULL)                        ns = 0;
         else if (!en)                         ns = 0;
         else if (tk && !rf && t == TO - 1)    ns = 2;
      end else begin
         if (ack) ns = 0;
      end
      if (ns != s) nt = 0;
      m_st  = ns;
      m_tmr = nt;
   endtask

   task automatic compare_all();
      chk("dezenas",   int'(rolhas_dezenas),  m_cnt / 10);
      chk("unidades",  int'(rolhas_unidades), m_cnt % 10);
      chk("RO",        int'(RO),              (m_cnt != 0) ? 1 : 0);
      chk("VE",        int'(VE),              (m_st == 1) ? 1 : 0);
      chk("ALARME",    int'(ALARME),          (m_st == 2) ? 1 : 0);
      chk("underflow", int'(underflow),       m_uf);
      chk("state",     int'(state),           m_st);
   endtask

   task automatic step(input bit en, input bit cons, input bit rf, input bit tk, input bit ack);
      enabled = en; consume = cons; refill_pulse = rf; tick = tk; alarm_ack = ack;
      @(posedge clock);
      model_update(en, cons, rf, tk, ack);
      #1;
      compare_all();
   endtask

   typedef struct {
      bit en, cons, rf, tk, ack;
      int e_cnt;
      int e_uf;
      int e_st;
   } vec_t;

   vec_t vt[10];

   initial begin
      // en cons rf tk ack | count uf state
      vt[0] = '{0,1,0,0,0, 0,1,0};
      vt[1] = '{0,0,0,0,0, 0,0,0};
      vt[2] = '{0,0,1,0,0, 1,0,0};
      vt[3] = '{0,1,1,0,0, 1,0,0};
      vt[4] = '{0,1,0,0,0, 0,0,0};
      vt[5] = '{0,1,0,0,0, 0,1,0};
      vt[6] = '{0,1,1,0,0, 0,0,0};
      vt[7] = '{1,0,0,0,0, 0,0,1};
      vt[8] = '{1,0,0,1,0, 0,0,1};
      vt[9] = '{0,0,0,0,0, 0,0,0};

      // reset held with random inputs
      reset = 1'b0;
      model_reset();
      for (int i = 0; i < 4; i++)
         step(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      chk("rst_state", int'(state), 0);
      chk("rst_RO", int'(RO), 0);
      reset = 1'b1;
      for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0);
      chk("idle_disabled", int'(state), 0);

      // vector table
      for (int i = 0; i < 10; i++) begin
         step(vt[i].en, vt[i].cons, vt[i].rf, vt[i].tk, vt[i].ack);
         chk($sformatf("vec%0d_cnt", i), dut_cnt(), vt[i].e_cnt);
         chk($sformatf("vec%0d_uf", i), int'(underflow), vt[i].e_uf);
         chk($sformatf("vec%0d_st", i), int'(state), vt[i].e_st);
      end

      // full refill from 00
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      chk("refill_VE_on", int'(VE), 1);
      for (int p = 1; p <= 20; p++) begin
         step(1, 0, 1, 0, 0);
         if (p == 20) begin
            chk("full_dez", int'(rolhas_dezenas), 2);
            chk("full_uni", int'(rolhas_unidades), 0);
            chk("full_RO", int'(RO), 1);
         end
         step(1, 0, 0, 0, 0);
         if (p == 20) begin
            chk("full_VE_off", int'(VE), 0);
            chk("full_state", int'(state), 0);
         end
         step(1, 0, 0, 0, 0);
      end

      // consumption with BCD borrow down to 05
      for (int i = 1; i <= 15; i++) begin
         step(1, 1, 0, 0, 0);
         chk("cons_seq", dut_cnt(), 20 - i);
      end
      step(1, 0, 0, 0, 0);
      chk("low_state", int'(state), 1);
      chk("low_VE", int'(VE), 1);

      // disable during REFILL
      step(0, 0, 0, 0, 0);
      chk("dis_state", int'(state), 0);
      chk("dis_cnt", dut_cnt(), 5);

      // boundaries
      for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0);
      step(0, 1, 1, 0, 0);
      chk("both_09", dut_cnt(), 9);
      step(0, 0, 1, 0, 0);
      chk("carry_dez", int'(rolhas_dezenas), 1);
      chk("carry_uni", int'(rolhas_unidades), 0);
      for (int i = 0; i < 89; i++) step(0, 0, 1, 0, 0);
      chk("at_99", dut_cnt(), 99);
      step(0, 0, 1, 0, 0);
      chk("sat_99", dut_cnt(), 99);
      for (int i = 0; i < 99; i++) step(0, 1, 0, 0, 0);
      chk("at_00", dut_cnt(), 0);
      step(0, 1, 0, 0, 0);
      chk("uf_cnt", dut_cnt(), 0);
      chk("uf_pulse", int'(underflow), 1);
      step(0, 0, 0, 0, 0);
      chk("uf_clear", int'(underflow), 0);

      // timeout
      step(1, 0, 0, 0, 0);
      for (int k = 1; k <= 8; k++) begin
         step(1, 0, 0, 1, 0);
         if (k == 7) chk("to_pre", int'(state), 1);
      end
      chk("to_state", int'(state), 2);
      chk("to_VE", int'(VE), 0);
      chk("to_ALARME", int'(ALARME), 1);
      step(1, 0, 0, 0, 1);
      chk("ack_state", int'(state), 0);
      step(1, 0, 0, 0, 0);
      chk("reentry_state", int'(state), 1);

      // pulse on the 7th tick clears the timer
      for (int k = 1; k <= 6; k++) step(1, 0, 0, 1, 0);
      step(1, 0, 1, 1, 0);
      chk("pulse7_state", int'(state), 1);
      for (int k = 1; k <= 7; k++) step(1, 0, 0, 1, 0);
      chk("pulse7_nofault", int'(state), 1);
      step(1, 0, 0, 1, 0);
      chk("pulse7_fault", int'(state), 2);
      step(1, 0, 0, 0, 1);
      step(1, 0, 0, 0, 0);
      chk("reentry2", int'(state), 1);

      // asynchronous reset mid-REFILL at 03
      step(1, 0, 1, 0, 0);
      step(1, 0, 1, 0, 0);
      chk("pre_rst_cnt", dut_cnt(), 3);
      chk("pre_rst_VE", int'(VE), 1);
      #2;
      reset = 1'b0;
      #1;
      model_reset();
      compare_all();
      chk("async_VE", int'(VE), 0);
      chk("async_cnt", dut_cnt(), 0);
      step(1, 0, 1, 0, 0);
      reset = 1'b1;

      // random traffic against the model
      for (int i = 0; i < 3000; i++)
         step(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 3) == 0),
              1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0),
              1'($urandom_range(0, 15) == 0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
